// File: rtl/spi_share_arb.sv
// spi_share_arb: transaction-granular owner arbitration for one shared SPI chip port.
// Requester 0 is the capture engine and requester 1 is the PS bus engine.
// Provides guard time between owners, a fairness limit for requester 0, and a hold watchdog.
module spi_share_arb #(
  parameter int unsigned GUARD_CYC = 4,
  parameter int unsigned TMO_W     = 16,
  parameter int unsigned TMO_CYC   = 50000,
  parameter int unsigned FAIR_MAX  = 4,
  parameter bit          CPOL      = 1'b0
) (
  input  logic clk125,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  input  logic m0_sck,
  input  logic m0_csn,
  input  logic m0_sdi,
  output logic m0_sdo,
  input  logic m1_sck,
  input  logic m1_csn,
  input  logic m1_sdi,
  output logic m1_sdo,
  output logic spi_sck,
  output logic spi_csn,
  output logic spi_sdi,
  input  logic spi_sdo,
  output logic busy,
  output logic tmo_err,
  output logic tmo_src
);

  localparam int unsigned GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int unsigned SW = (FAIR_MAX > 0) ? $clog2(FAIR_MAX + 1) : 1;
  localparam logic [GW-1:0]    GUARD_LAST = GW'(GUARD_CYC - 1);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(FAIR_MAX);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TMO_CYC - 1);
  localparam bit               WD_EN      = (TMO_CYC != 0);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GUARD} state_t;

  state_t           state, state_nx;
  logic [GW-1:0]    gcnt, gcnt_nx;
  logic [TMO_W-1:0] wdog, wdog_nx;
  logic [SW-1:0]    streak, streak_nx;
  logic [1:0]       lock, lock_nx;
  logic             tmo_err_nx, tmo_src_nx;
  logic             elig0, elig1;

  assign elig0 = req0 & ~lock[0];
  assign elig1 = req1 & ~lock[1];

  // State, counters and registered status outputs.
  always_ff @(posedge clk125) begin
    if (rst) begin
      state   <= IDLE;
      gcnt    <= '0;
      wdog    <= '0;
      streak  <= '0;
      lock    <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      tmo_err <= 1'b0;
      tmo_src <= 1'b0;
    end else begin
      state   <= state_nx;
      gcnt    <= gcnt_nx;
      wdog    <= wdog_nx;
      streak  <= streak_nx;
      lock    <= lock_nx;
      gnt0    <= (state_nx == OWN0);
      gnt1    <= (state_nx == OWN1);
      busy    <= (state_nx != IDLE);
      tmo_err <= tmo_err_nx;
      tmo_src <= tmo_src_nx;
    end
  end

  // Arbitration, release, guard timing and watchdog revoke.
  always_comb begin
    state_nx   = state;
    gcnt_nx    = '0;
    wdog_nx    = '0;
    streak_nx  = streak;
    lock_nx    = lock & {req1, req0};
    tmo_err_nx = 1'b0;
    tmo_src_nx = tmo_src;
    case (state)
      IDLE: begin
        if (elig0 && !(elig1 && (streak == STREAK_MAX))) begin
          state_nx = OWN0;
          if (elig1) streak_nx = streak + SW'(1);
        end else if (elig1) begin
          state_nx  = OWN1;
          streak_nx = '0;
        end
      end
      OWN0: begin
        wdog_nx = wdog + TMO_W'(1);
        if (!req0) begin
          state_nx = GUARD;
        end else if (WD_EN && (wdog == TMO_LAST)) begin
          state_nx   = GUARD;
          tmo_err_nx = 1'b1;
          tmo_src_nx = 1'b0;
          lock_nx[0] = 1'b1;
        end
      end
      OWN1: begin
        wdog_nx = wdog + TMO_W'(1);
        if (!req1) begin
          state_nx = GUARD;
        end else if (WD_EN && (wdog == TMO_LAST)) begin
          state_nx   = GUARD;
          tmo_err_nx = 1'b1;
          tmo_src_nx = 1'b1;
          lock_nx[1] = 1'b1;
        end
      end
      GUARD: begin
        gcnt_nx = gcnt + GW'(1);
        if (gcnt == GUARD_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pin mux follows the registered owner; idle pins when nobody owns the port.
  always_comb begin
    spi_csn = 1'b1;
    spi_sck = CPOL;
    spi_sdi = 1'b0;
    m0_sdo  = 1'b0;
    m1_sdo  = 1'b0;
    case (state)
      OWN0: begin
        spi_csn = m0_csn;
        spi_sck = m0_sck;
        spi_sdi = m0_sdi;
        m0_sdo  = spi_sdo;
      end
      OWN1: begin
        spi_csn = m1_csn;
        spi_sck = m1_sck;
        spi_sdi = m1_sdi;
        m1_sdo  = spi_sdo;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_share_arb.sv
// tb_spi_share_arb: directed vector table plus sequences for fairness, watchdog and reset.
module tb_spi_share_arb;

  logic clk125 = 1'b0;
  logic rst, req0, req1;
  logic gnt0, gnt1;
  logic m0_sck, m0_csn, m0_sdi, m0_sdo;
  logic m1_sck, m1_csn, m1_sdi, m1_sdo;
  logic spi_sck, spi_csn, spi_sdi, spi_sdo;
  logic busy, tmo_err, tmo_src;

  int total = 0;
  int bad   = 0;

  spi_share_arb #(
    .GUARD_CYC(4), .TMO_W(16), .TMO_CYC(100), .FAIR_MAX(4), .CPOL(1'b0)
  ) dut (
    .clk125(clk125), .rst(rst), .req0(req0), .req1(req1),
    .gnt0(gnt0), .gnt1(gnt1),
    .m0_sck(m0_sck), .m0_csn(m0_csn), .m0_sdi(m0_sdi), .m0_sdo(m0_sdo),
    .m1_sck(m1_sck), .m1_csn(m1_csn), .m1_sdi(m1_sdi), .m1_sdo(m1_sdo),
    .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo),
    .busy(busy), .tmo_err(tmo_err), .tmo_src(tmo_src)
  );

  always #5 clk125 = ~clk125;

  // Inputs per cycle and the outputs expected during that same cycle.
  // exp = {gnt0,gnt1,busy,spi_csn,spi_sck,spi_sdi,m0_sdo,m1_sdo,tmo_err}
  typedef struct packed {
    logic [1:0] req;
    logic [2:0] m0;
    logic [2:0] m1;
    logic       sdo;
    logic [8:0] exp;
  } vec_t;

  vec_t vt [20];

  function automatic vec_t mk(input logic [1:0] req, input logic [2:0] m0,
                              input logic [2:0] m1, input logic sdo, input logic [8:0] e);
    vec_t v;
    v.req = req; v.m0 = m0; v.m1 = m1; v.sdo = sdo; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk125);
    #1;
  endtask

  task automatic idle_pins();
    m0_sck = 1'b0; m0_csn = 1'b1; m0_sdi = 1'b0;
    m1_sck = 1'b0; m1_csn = 1'b1; m1_sdi = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    idle_pins();
    nxt(); nxt();
    rst = 1'b0;
  endtask

  // Returns at the negedge of the first cycle with a grant; who=-1 if none within lim.
  task automatic wait_gnt(input int lim, output int who, output int cyc);
    who = -1; cyc = 0;
    for (int i = 0; i < lim && who < 0; i++) begin
      @(negedge clk125);
      if (gnt0) who = 0;
      else if (gnt1) who = 1;
      else begin nxt(); cyc++; end
    end
  endtask

  // Counts edges until the selected grant falls; returns at that cycle's negedge.
  task automatic count_high(input bit sel, input int lim, output int n);
    bit done;
    n = 0; done = 1'b0;
    for (int i = 0; i < lim && !done; i++) begin
      nxt(); n++;
      @(negedge clk125);
      if (!(sel ? gnt1 : gnt0)) done = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int who, cyc, n;
    bit seen;
    int fexp [5];
    fexp = '{0, 0, 0, 0, 1};

    vt[0]  = mk(2'b00, 3'b101, 3'b100, 1'b1, 9'b000100000);
    vt[1]  = mk(2'b01, 3'b101, 3'b100, 1'b1, 9'b000100000);
    vt[2]  = mk(2'b01, 3'b101, 3'b101, 1'b1, 9'b011011010);
    vt[3]  = mk(2'b01, 3'b101, 3'b000, 1'b0, 9'b011000000);
    vt[4]  = mk(2'b00, 3'b101, 3'b010, 1'b1, 9'b011100010);
    vt[5]  = mk(2'b00, 3'b101, 3'b101, 1'b1, 9'b001100000);
    vt[6]  = mk(2'b11, 3'b101, 3'b101, 1'b1, 9'b001100000);
    vt[7]  = mk(2'b11, 3'b101, 3'b101, 1'b1, 9'b001100000);
    vt[8]  = mk(2'b11, 3'b101, 3'b101, 1'b1, 9'b001100000);
    vt[9]  = mk(2'b11, 3'b101, 3'b101, 1'b1, 9'b000100000);
    vt[10] = mk(2'b11, 3'b101, 3'b101, 1'b1, 9'b101011100);
    vt[11] = mk(2'b01, 3'b000, 3'b101, 1'b0, 9'b101000000);
    vt[12] = mk(2'b01, 3'b101, 3'b101, 1'b1, 9'b001100000);
    vt[13] = mk(2'b01, 3'b101, 3'b101, 1'b1, 9'b001100000);
    vt[14] = mk(2'b01, 3'b101, 3'b101, 1'b1, 9'b001100000);
    vt[15] = mk(2'b01, 3'b101, 3'b101, 1'b1, 9'b001100000);
    vt[16] = mk(2'b01, 3'b101, 3'b101, 1'b1, 9'b000100000);
    vt[17] = mk(2'b00, 3'b101, 3'b101, 1'b0, 9'b011011000);
    vt[18] = mk(2'b00, 3'b101, 3'b101, 1'b0, 9'b001100000);
    vt[19] = mk(2'b00, 3'b101, 3'b101, 1'b0, 9'b001100000);

    // Reset with requester pins active: port must still look idle.
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; spi_sdo = 1'b1;
    m0_sck = 1'b1; m0_csn = 1'b0; m0_sdi = 1'b1;
    m1_sck = 1'b1; m1_csn = 1'b0; m1_sdi = 1'b1;
    nxt(); nxt();
    @(negedge clk125);
    chk("reset", {gnt0, gnt1, busy, tmo_err, tmo_src, spi_csn, spi_sck, spi_sdi, m0_sdo, m1_sdo},
        10'b00000_10000);
    rst = 1'b0;
    nxt();

    // Single request, release/guard timing, SDO isolation, contention.
    for (int i = 0; i < 20; i++) begin
      {req0, req1} = vt[i].req;
      {m0_sck, m0_csn, m0_sdi} = vt[i].m0;
      {m1_sck, m1_csn, m1_sdi} = vt[i].m1;
      spi_sdo = vt[i].sdo;
      @(negedge clk125);
      chk($sformatf("vec%0d", i),
          {gnt0, gnt1, busy, spi_csn, spi_sck, spi_sdi, m0_sdo, m1_sdo, tmo_err}, vt[i].exp);
      nxt();
    end

    // Fairness: req1 held, req0 re-requests after each transaction.
    do_reset();
    req1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req0 = 1'b1;
      wait_gnt(20, who, cyc);
      chk($sformatf("fair%0d", k), who, fexp[k]);
      if (who == 1) begin req1 = 1'b0; req0 = 1'b0; end
      else req0 = 1'b0;
      nxt();
    end
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt(20, who, cyc);
    chk("fair_after_reset_streak", who, 0);
    req0 = 1'b0; req1 = 1'b0;
    nxt();

    // Watchdog on requester 0, then on requester 1.
    do_reset();
    req0 = 1'b1;
    wait_gnt(10, who, cyc);
    chk("wd_first_gnt", who, 0);
    req1 = 1'b1;
    count_high(1'b0, 200, n);
    chk("wd0_hold_cycles", n, 100);
    chk("wd0_err_src", {tmo_err, tmo_src, gnt0}, 3'b100);
    nxt();
    @(negedge clk125);
    chk("wd0_err_pulse_end", tmo_err, 0);
    nxt();
    wait_gnt(20, who, cyc);
    chk("wd_req1_after_guard", who, 1);
    chk("wd_req1_gap", cyc, 3);
    count_high(1'b1, 200, n);
    chk("wd1_hold_cycles", n, 100);
    chk("wd1_err_src", {tmo_err, tmo_src, gnt1}, 3'b110);
    req1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      nxt();
      @(negedge clk125);
      if (gnt0 || gnt1) seen = 1'b1;
    end
    chk("wd_lockout_holds", seen, 0);
    req0 = 1'b0;
    nxt();
    req0 = 1'b1;
    wait_gnt(10, who, cyc);
    chk("wd_regrant_after_low", who, 0);
    chk("wd_regrant_latency", cyc, 1);
    chk("wd_src_held", tmo_src, 1);
    req0 = 1'b0;
    nxt();

    // Reset in the middle of an OWN1 transfer.
    do_reset();
    req1 = 1'b1;
    wait_gnt(10, who, cyc);
    chk("rst_pre_gnt", who, 1);
    m1_csn = 1'b0; m1_sck = 1'b1; m1_sdi = 1'b1;
    nxt();
    @(negedge clk125);
    chk("rst_pre_pins", {spi_csn, spi_sck, spi_sdi}, 3'b011);
    rst = 1'b1;
    nxt();
    @(negedge clk125);
    chk("rst_mid", {gnt0, gnt1, busy, spi_csn, spi_sck, spi_sdi}, 6'b000100);
    rst = 1'b0;
    wait_gnt(5, who, cyc);
    chk("rst_regrant", who, 1);
    chk("rst_regrant_latency", cyc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
